// File: rtl/stack_muldiv_unit.sv
// Iterative multiply/divide stage that pops two stack operands, runs one bit per cycle,
// then pushes the single result back onto the operand stack.
module stack_muldiv_unit #(
    parameter int DBITS = 32,
    parameter int CBITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             st_en1,
    output logic             st_en2,
    output logic             st_we,
    output logic [DBITS-1:0] st_din,
    input  logic [DBITS-1:0] st_dout1,
    input  logic [DBITS-1:0] st_dout2
);

    typedef enum logic [1:0] {IDLE, POP, EXEC, PUSH} state_t;

    localparam logic [CBITS-1:0] LAST = CBITS'(DBITS - 1);

    state_t           state, state_next;
    logic [1:0]       op_q;
    logic [DBITS-1:0] a, b, acc;
    logic [CBITS-1:0] cnt;

    logic [DBITS:0]   mul_sum;
    logic [DBITS+1:0] div_diff;
    logic             div_ok;
    logic [DBITS-1:0] result;

    // a doubles as multiplier/low product and as dividend/quotient; acc holds high product or remainder
    assign mul_sum  = {1'b0, acc} + (a[0] ? {1'b0, b} : '0);
    assign div_diff = {1'b0, acc, a[DBITS-1]} - {2'b00, b};
    assign div_ok   = ~div_diff[DBITS+1];
    assign result   = op_q[0] ? acc : a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= '0;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) op_q <= op;
                POP: begin
                    a   <= st_dout2;
                    b   <= st_dout1;
                    acc <= '0;
                    cnt <= '0;
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (!op_q[1]) begin
                        acc <= mul_sum[DBITS:1];
                        a   <= {mul_sum[0], a[DBITS-1:1]};
                    end else if (div_ok) begin
                        acc <= div_diff[DBITS-1:0];
                        a   <= {a[DBITS-2:0], 1'b1};
                    end else begin
                        acc <= {acc[DBITS-2:0], a[DBITS-1]};
                        a   <= {a[DBITS-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div0       = 1'b0;
        st_en1     = 1'b0;
        st_en2     = 1'b0;
        st_we      = 1'b0;
        st_din     = '0;
        case (state)
            IDLE: if (start) state_next = POP;
            POP: begin
                busy       = 1'b1;
                st_en1     = 1'b1;
                st_en2     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = PUSH;
            end
            PUSH: begin
                busy       = 1'b1;
                done       = 1'b1;
                st_we      = 1'b1;
                st_din     = result;
                div0       = op_q[1] && (b == '0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_muldiv_unit.sv
// Bench for stack_muldiv_unit: a queue-based operand stack plus a timeline/arithmetic
// reference model checked every cycle, and directed vectors with literal results.
module tb_stack_muldiv_unit;

    localparam int DBITS = 32;
    localparam int LAT   = DBITS + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        busy, done, div0, st_en1, st_en2, st_we;
    logic [31:0] st_din;
    logic [31:0] st_dout1 = '0;
    logic [31:0] st_dout2 = '0;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] stk[$];
    int          m_cnt = 0;
    logic [1:0]  m_op = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          done_count = 0;
    int          we_count   = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    stack_muldiv_unit #(.DBITS(DBITS), .CBITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .busy(busy), .done(done), .div0(div0),
        .st_en1(st_en1), .st_en2(st_en2), .st_we(st_we), .st_din(st_din),
        .st_dout1(st_dout1), .st_dout2(st_dout2)
    );

    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // m_cnt counts cycles since the accepted start: 1 is the pop cycle, LAT the push cycle
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt = 1;
                m_op  = op;
            end
        end else begin
            if (m_cnt == 1) begin
                m_b = (stk.size() > 0) ? stk[stk.size()-1] : 'x;
                m_a = (stk.size() > 1) ? stk[stk.size()-2] : 'x;
            end
            m_cnt = (m_cnt == LAT) ? 0 : m_cnt + 1;
        end
        if (done === 1'b1) done_count++;
        if (st_we === 1'b1) we_count++;
        if (st_en1 === 1'b1 && st_en2 === 1'b1) begin
            if (stk.size() > 0) void'(stk.pop_back());
            if (stk.size() > 0) void'(stk.pop_back());
        end
        if (st_we === 1'b1) stk.push_back(st_din);
        st_dout1 <= (stk.size() > 0) ? stk[stk.size()-1] : '0;
        st_dout2 <= (stk.size() > 1) ? stk[stk.size()-2] : '0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_done;
            exp_done = (m_cnt == LAT);
            checkOutput("busy",   busy,   m_cnt != 0);
            checkOutput("st_en1", st_en1, m_cnt == 1);
            checkOutput("st_en2", st_en2, m_cnt == 1);
            checkOutput("st_we",  st_we,  exp_done);
            checkOutput("done",   done,   exp_done);
            checkOutput("div0",   div0,   exp_done && m_op[1] && (m_b == 0));
            checkOutput("st_din", st_din, exp_done ? model_result(m_op, m_a, m_b) : 32'h0);
        end
    end

    // Called at a negedge with the unit idle; returns at the negedge of the pop cycle
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        stk.push_back(a);
        stk.push_back(b);
        op    = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic [31:0] exp_lit, input logic exp_div0, input int restart_at);
        int cycles;
        int depth0;
        int dc0;
        depth0 = stk.size();
        dc0    = done_count;
        applyStimulus(a, b, o);
        cycles = 1;
        while (done !== 1'b1 && cycles < LAT + 5) begin
            @(negedge clk);
            cycles++;
            start = (restart_at != 0) && (cycles == restart_at);
            if (start) op = o ^ 2'b01;
        end
        checkOutput({name, "_done_seen"}, done, 1'b1);
        checkOutput({name, "_latency"}, cycles, LAT);
        checkOutput({name, "_result"}, st_din, exp_lit);
        checkOutput({name, "_div0"}, div0, exp_div0);
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, "_stack_top"}, (stk.size() > 0) ? stk[stk.size()-1] : 'x, exp_lit);
        checkOutput({name, "_stack_depth"}, stk.size(), depth0 + 1);
        checkOutput({name, "_done_pulses"}, done_count - dc0, 1);
    endtask

    initial begin
        int dc0;
        int wc0;
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ctrl", {st_en1, st_en2, st_we}, 3'b000);
        checkOutput("reset_st_din", st_din, 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", busy, 1'b0);

        runOp("mul",     32'd6,         32'd7, 2'b00, 32'd42,        1'b0, 0);
        runOp("mulhu",   32'hFFFF_FFFF, 32'd2, 2'b01, 32'h0000_0001, 1'b0, 0);
        runOp("mul_lo",  32'hFFFF_FFFF, 32'd2, 2'b00, 32'hFFFF_FFFE, 1'b0, 0);
        runOp("divu",    32'd100,       32'd7, 2'b10, 32'd14,        1'b0, 0);
        runOp("remu",    32'd100,       32'd7, 2'b11, 32'd2,         1'b0, 0);
        runOp("divu_z",  32'd5,         32'd0, 2'b10, 32'hFFFF_FFFF, 1'b1, 0);
        runOp("remu_z",  32'd5,         32'd0, 2'b11, 32'd5,         1'b1, 0);
        runOp("busy_st", 32'd100,       32'd7, 2'b10, 32'd14,        1'b0, 9);
        runOp("push_st", 32'd6,         32'd7, 2'b00, 32'd42,        1'b0, LAT);
        checkOutput("push_start_ignored", busy, 1'b0);

        dc0 = done_count;
        wc0 = we_count;
        stk.delete();
        applyStimulus(32'd3, 32'd4, 2'b00);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        checkOutput("midrst_no_done", done_count - dc0, 0);
        checkOutput("midrst_no_we", we_count - wc0, 0);
        checkOutput("midrst_popped", stk.size(), 0);
        runOp("after_rst", 32'd9, 32'd9, 2'b00, 32'd81, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_muldiv_unit.md
Name: stack_muldiv_unit

Overview:
- Multi-cycle multiply/divide execute stage that sits directly in front of the operand stack and feeds it.
- On a start command it pops the top two stack entries in one cycle and runs an iterative 1-bit-per-cycle multiply or divide.
- It then pushes the single result back onto the stack, for a net stack depth change of -1.
- The main controller hands stack control to this block while busy=1; the controller's own en1/en2/we are muxed out during that window.

Parameters:
- DBITS, 32, data width of the stack entries and operands.
- CBITS, 5, iteration counter width; must satisfy 2^CBITS = DBITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe from the controller, sampled only in IDLE.
- op  input  2  operation: 00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU (quotient), 11 REMU (remainder).
- busy  output  1  high from the POP cycle through the PUSH cycle inclusive.
- done  output  1  one-cycle pulse, coincident with the PUSH cycle.
- div0  output  1  one-cycle pulse with done when op is DIVU/REMU and the divisor is 0.
- st_en1  output  1  to stack en1 (top-of-stack read/pop).
- st_en2  output  1  to stack en2 (second-entry read/pop).
- st_we  output  1  to stack we (push).
- st_din  output  DBITS  result data to stack din.
- st_dout1  input  DBITS  stack top-of-stack (operand b).
- st_dout2  input  DBITS  stack second entry (operand a).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, div0=0, st_en1=0, st_en2=0, st_we=0, st_din=0; internal a, b, acc and counter all 0.
- FSM: IDLE -> POP -> EXEC -> PUSH -> IDLE. Stack-control outputs decode combinationally from the registered state.
- IDLE: all st_* = 0, so the stack holds sp. If start=1, latch op and go to POP.
- POP (1 cycle): st_en1=1, st_en2=1, st_we=0, so the stack pops two. At the closing edge, capture a=st_dout2, b=st_dout1, clear the counter and clear acc/remainder. Go to EXEC.
- EXEC (exactly DBITS cycles): st_* = 0.
  - MUL/MULHU: shift-add, 2*DBITS-bit product.
  - DIVU/REMU: restoring division, DBITS-bit quotient and DBITS-bit remainder.
  - Counter increments 0..DBITS-1; at count DBITS-1, go to PUSH.
- PUSH (1 cycle): st_we=1, st_en1=0, st_en2=0, st_din=selected result, done=1, div0 per rule. Go to IDLE.
- Latency: with start sampled at edge T, POP occupies cycle T+1, EXEC occupies T+2..T+DBITS+1, and PUSH occupies T+DBITS+2 (T+34 at default). Latency is constant for every op and operand value.
- Operand order: the result is a op b, where a is the deeper entry. MUL = low DBITS of a*b; MULHU = high DBITS of unsigned a*b; DIVU = a/b; REMU = a%b, all unsigned.
- Divide by zero (b=0): quotient = all ones, remainder = a, div0=1 in the PUSH cycle. This falls out of restoring division naturally and needs no special path; latency is unchanged.
- start while busy=1 is ignored, not queued. op changes after the start edge have no effect.
- start asserted in the PUSH cycle is ignored. The next command is accepted at the earliest one cycle after done.
- rst mid-operation: return to IDLE next edge with all outputs 0 and no push. Entries already popped are lost; the controller must reset the stack as well.
- No overflow or carry flags. MUL wraps modulo 2^DBITS.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, st_en1/st_en2/st_we=0, st_din=0; no POP occurs.
- MUL: stack top=7, second=6, op=00, start pulse -> POP at T+1 (en1=en2=1, we=0), done and we=1 at T+34, st_din=42; the stack model's sp is net -1 and the new top is 42.
- MULHU: a=32'hFFFF_FFFF, b=32'h0000_0002, op=01 -> st_din=32'h0000_0001. Same operands with op=00 -> st_din=32'hFFFF_FFFE.
- DIVU/REMU: a=100, b=7 -> op=10 gives 14, op=11 gives 2, div0=0. a=5, b=0 -> DIVU gives 32'hFFFF_FFFF, REMU gives 5, and div0 pulses with done.
- Start during busy: re-pulse start at T+10 with a different op -> ignored, exactly one done at T+34, result from the original op. A start at T+35 is accepted.
- Reset mid-op: assert rst at T+20 -> IDLE next edge, no done, st_we never asserts; a fresh command afterwards completes normally in 34 cycles.
